// File: rtl/adbg_or1k_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adbg_or1k_pkg : shared types for the OR1K debug halt sequencer     |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
package adbg_or1k_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    HALT_REQ = 3'd1,
    HALTED   = 3'd2,
    RESUME   = 3'd3,
    RESET    = 3'd4
  } halt_state_t;

  function automatic logic drives_halt(input halt_state_t s);
    return (s == HALT_REQ) || (s == HALTED);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adbg_or1k_halt_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adbg_or1k_halt_fsm : single-core halt/resume/reset handshake FSM   |
// | Optional halt timer/flag: ADBG_HALT_TIMEOUT_EN                     |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module adbg_or1k_halt_fsm
  import adbg_or1k_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic cpu_clk_i,
  input  logic cpu_rstn_i,
  input  logic stall_req_i,
  input  logic rst_req_i,
  input  logic core_halted_i,
  input  logic clr_timeout_i,
  output logic core_halt_o,
  output logic core_rst_o,
  output logic halted_o,
  output logic timeout_o
);

  localparam int RW = $clog2(RST_CYCLES);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);

  halt_state_t   state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          core_halt_q, core_rst_q, halted_q;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (rst_req_i && (state_q != RESET)) begin
      state_d = RESET;
      rcnt_d  = RST_LOAD;
    end else begin
      unique case (state_q)
        RUN:      if (stall_req_i) state_d = HALT_REQ;
        HALT_REQ: begin
          if (core_halted_i)     state_d = HALTED;
          else if (!stall_req_i) state_d = RESUME;
        end
        HALTED:   if (!stall_req_i) state_d = RESUME;
        RESUME: begin
          if (stall_req_i)         state_d = HALT_REQ;
          else if (!core_halted_i) state_d = RUN;
        end
        RESET: begin
          // The count runs from entry only, so a long request stretches the pulse exactly.
          if (rcnt_q != '0)  rcnt_d  = rcnt_q - RW'(1);
          else if (!rst_req_i) state_d = stall_req_i ? HALT_REQ : RUN;
        end
        default:  state_d = RUN;
      endcase
    end
  end

`ifdef ADBG_HALT_TIMEOUT_EN
  localparam int TW = $clog2(HALT_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_MAX  = TW'(HALT_TIMEOUT);
  localparam logic [TW-1:0] TMR_TRIP = TW'(HALT_TIMEOUT - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    tmr_d     = tmr_q;
    timeout_d = timeout_q;
    if (clr_timeout_i) timeout_d = 1'b0;
    // Every fresh halt request starts timing from zero.
    if ((state_d == HALT_REQ) && (state_q != HALT_REQ)) begin
      tmr_d = '0;
    end else if ((state_q == HALT_REQ) && (state_d == HALT_REQ)) begin
      if (tmr_q == TMR_TRIP) timeout_d = 1'b1;
      if (tmr_q != TMR_MAX)  tmr_d     = tmr_q + TW'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = clr_timeout_i ^ (HALT_TIMEOUT != 0);
`endif

  always_ff @(posedge cpu_clk_i) begin
    if (!cpu_rstn_i) begin
      state_q     <= RUN;
      rcnt_q      <= '0;
      core_halt_q <= 1'b0;
      core_rst_q  <= 1'b0;
      halted_q    <= 1'b0;
`ifdef ADBG_HALT_TIMEOUT_EN
      tmr_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      core_halt_q <= drives_halt(state_d);
      core_rst_q  <= (state_d == RESET);
      halted_q    <= (state_d == HALTED);
`ifdef ADBG_HALT_TIMEOUT_EN
      tmr_q       <= tmr_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign core_halt_o = core_halt_q;
  assign core_rst_o  = core_rst_q;
  assign halted_o    = halted_q;
`ifdef ADBG_HALT_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`else
  assign timeout_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/adbg_or1k_halt_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adbg_or1k_halt_seq : per-core halt/reset sequencer (wiring only)   |
// | Optional halt timer/flag: ADBG_HALT_TIMEOUT_EN                     |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module adbg_or1k_halt_seq
  import adbg_or1k_pkg::*;
#(
  parameter int NB_CORES     = 4,
  parameter int RST_CYCLES   = 16,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic                cpu_clk_i,
  input  logic                cpu_rstn_i,
  input  logic [NB_CORES-1:0] stall_req_i,
  input  logic [NB_CORES-1:0] rst_req_i,
  input  logic [NB_CORES-1:0] core_halted_i,
  input  logic [NB_CORES-1:0] clr_timeout_i,
  output logic [NB_CORES-1:0] core_halt_o,
  output logic [NB_CORES-1:0] core_rst_o,
  output logic [NB_CORES-1:0] halted_o,
  output logic [NB_CORES-1:0] timeout_o
);

  for (genvar i = 0; i < NB_CORES; i++) begin : g_core
    adbg_or1k_halt_fsm #(
      .RST_CYCLES   (RST_CYCLES),
      .HALT_TIMEOUT (HALT_TIMEOUT)
    ) u_fsm (
      .cpu_clk_i     (cpu_clk_i),
      .cpu_rstn_i    (cpu_rstn_i),
      .stall_req_i   (stall_req_i[i]),
      .rst_req_i     (rst_req_i[i]),
      .core_halted_i (core_halted_i[i]),
      .clr_timeout_i (clr_timeout_i[i]),
      .core_halt_o   (core_halt_o[i]),
      .core_rst_o    (core_rst_o[i]),
      .halted_o      (halted_o[i]),
      .timeout_o     (timeout_o[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_adbg_or1k_halt_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_adbg_or1k_halt_seq : directed bench for adbg_or1k_halt_seq      |
// | Revision              : 1.0                                        |
// +--------------------------------------------------------------------+
module tb_adbg_or1k_halt_seq;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NB-1:0] stall, rreq, ack, clr;
  logic [NB-1:0] halt_o, rst_o, halted_o, timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adbg_or1k_halt_seq #(
    .NB_CORES     (NB),
    .RST_CYCLES   (16),
    .HALT_TIMEOUT (8)
  ) u_dut (
    .cpu_clk_i     (clk),
    .cpu_rstn_i    (rstn),
    .stall_req_i   (stall),
    .rst_req_i     (rreq),
    .core_halted_i (ack),
    .clr_timeout_i (clr),
    .core_halt_o   (halt_o),
    .core_rst_o    (rst_o),
    .halted_o      (halted_o),
    .timeout_o     (timeout_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    rstn = 1'b0; stall = '0; rreq = '0; ack = '0; clr = '0;
    tick(); tick();
    check_eq("rst_halt",    32'(halt_o),    32'h0);
    check_eq("rst_corerst", 32'(rst_o),     32'h0);
    check_eq("rst_halted",  32'(halted_o),  32'h0);
    check_eq("rst_timeout", 32'(timeout_o), 32'h0);
    rstn = 1'b1;
    tick();

    // Halt / resume round trip on core 0
    stall[0] = 1'b1; tick();
    check_eq("hr_halt_req",   32'(halt_o),   32'h1);
    check_eq("hr_not_halted", 32'(halted_o), 32'h0);
    tick(); tick();
    ack[0] = 1'b1; tick();
    check_eq("hr_halted",      32'(halted_o), 32'h1);
    check_eq("hr_halt_held",   32'(halt_o),   32'h1);
    stall[0] = 1'b0; tick();
    check_eq("hr_resume_halt",   32'(halt_o),   32'h0);
    check_eq("hr_resume_halted", 32'(halted_o), 32'h0);
    tick();
    ack[0] = 1'b0; tick();
    check_eq("hr_run_halt", 32'(halt_o), 32'h0);

    // A core halting on its own does not show as halted
    ack[3] = 1'b1; tick(); tick();
    check_eq("unreq_ack_halted", 32'(halted_o), 32'h0);
    ack[3] = 1'b0; tick();

    // One-cycle reset request on core 1 stretches to 16 cycles
    rreq[1] = 1'b1; tick(); rreq[1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!rst_o[1]) break;
      cnt++;
      tick();
    end
    check_eq("rst_pulse_1", 32'(cnt), 32'd16);
    check_eq("rst_only_c1", 32'(rst_o), 32'h0);

    // 40-cycle request gives exactly 40 cycles
    rreq[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rst_o[1]) cnt++;
    end
    rreq[1] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!rst_o[1]) break;
      cnt++;
    end
    check_eq("rst_pulse_40", 32'(cnt), 32'd40);

    // Reset pre-empts a halted core 2, then re-requests the halt
    stall[2] = 1'b1; tick();
    ack[2] = 1'b1; tick();
    check_eq("pre_halted", 32'(halted_o[2]), 32'h1);
    rreq[2] = 1'b1; tick();
    rreq[2] = 1'b0; ack[2] = 1'b0;
    check_eq("pre_halt_drop", 32'(halt_o[2]),   32'h0);
    check_eq("pre_rst_rise",  32'(rst_o[2]),    32'h1);
    check_eq("pre_halted_0",  32'(halted_o[2]), 32'h0);
    for (int i = 0; i < 15; i++) tick();
    check_eq("pre_rst_held", 32'(rst_o[2]), 32'h1);
    tick();
    check_eq("pre_rst_end",   32'(rst_o[2]),  32'h0);
    check_eq("pre_rehalt",    32'(halt_o[2]), 32'h1);
    stall[2] = 1'b0; tick(); tick();

`ifdef ADBG_HALT_TIMEOUT_EN
    // Halt timeout on core 0 with HALT_TIMEOUT = 8
    stall[0] = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check_eq("to_not_yet", 32'(timeout_o[0]), 32'h0);
    tick();
    check_eq("to_set",       32'(timeout_o[0]), 32'h1);
    check_eq("to_halt_held", 32'(halt_o[0]),    32'h1);
    tick(); tick();
    check_eq("to_sticky", 32'(timeout_o[0]), 32'h1);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    check_eq("to_cleared", 32'(timeout_o[0]), 32'h0);
    ack[0] = 1'b1; tick();
    check_eq("to_then_halted", 32'(halted_o[0]), 32'h1);
`else
    // Without the timer, HALT_REQ waits indefinitely and the flag stays low
    stall[0] = 1'b1; clr[0] = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    clr[0] = 1'b0;
    check_eq("nto_flag",      32'(timeout_o), 32'h0);
    check_eq("nto_halt_held", 32'(halt_o[0]), 32'h1);
    ack[0] = 1'b1; tick();
    check_eq("nto_halted", 32'(halted_o[0]), 32'h1);
`endif
    stall[0] = 1'b0; tick();
    ack[0] = 1'b0; tick();

    // Independent cores, then a one-edge synchronous reset
    stall[0] = 1'b1; rreq[2] = 1'b1; tick();
    rreq[2] = 1'b0; tick();
    check_eq("ind_halt", 32'(halt_o), 32'h1);
    check_eq("ind_rst",  32'(rst_o),  32'h4);
    rstn = 1'b0; tick();
    rstn = 1'b1; stall = '0;
    check_eq("srst_halt",    32'(halt_o),    32'h0);
    check_eq("srst_corerst", 32'(rst_o),     32'h0);
    check_eq("srst_halted",  32'(halted_o),  32'h0);
    check_eq("srst_timeout", 32'(timeout_o), 32'h0);
    tick();
    check_eq("srst_run_rst", 32'(rst_o), 32'h0);
    stall[2] = 1'b1; tick();
    check_eq("srst_run_halt", 32'(halt_o), 32'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
